calc_result_bcd: RTL and testbench

- Output stage directly downstream of the calculator's combinational ALU.
- Captures the 8-bit result and error flag through a valid/ready handshake.
- Converts the magnitude to packed BCD iteratively (shift-add-3 / double dabble), optionally interpreting the result as two's complement, and presents digits, sign and error to the display driver.

---
 rtl/calc_result_bcd_if.sv | 46 ++++
 rtl/calc_result_bcd.sv | 122 ++++++++++++
 tb/tb_calc_result_bcd.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/calc_result_bcd_if.sv
// calc_result_bcd_if: ALU result input handshake and BCD output handshake.
// Input side: in_valid/in_ready, result, error, signed_en. Output side: out_valid/out_ready, bcd, neg, err_out, busy.
interface calc_result_bcd_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      result;
  logic                  error;
  logic                  signed_en;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  err_out;
  logic                  busy;

  modport master (
    output in_valid,
    output result,
    output error,
    output signed_en,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  bcd,
    input  neg,
    input  err_out,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  result,
    input  error,
    input  signed_en,
    input  out_ready,
    output in_ready,
    output out_valid,
    output bcd,
    output neg,
    output err_out,
    output busy
  );
endinterface

// File: rtl/calc_result_bcd.sv
// calc_result_bcd: captures the ALU result and converts it to packed BCD by double dabble.
// Ports: clk, rst_n (async, active low), bus (slave side of calc_result_bcd_if).
module calc_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic              clk,
  input logic              rst_n,
  calc_result_bcd_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [BW-1:0]     scr_q;
  logic [BW-1:0]     scr_d;
  logic [BW-1:0]     adj;
  logic [WIDTH-1:0]  mag_q;
  logic [WIDTH-1:0]  mag_d;
  logic [WIDTH-1:0]  mag_in;
  logic              neg_in;
  logic              sneg_q;
  logic [BW-1:0]     bcd_q;
  logic              neg_q;
  logic              err_q;
  logic              ov_q;
  logic              busy_q;

  // The most negative input negates to 2^(WIDTH-1), which still fits
  // WIDTH bits when read as unsigned, so no extra magnitude bit is kept.
  always_comb begin
    neg_in = bus.signed_en & bus.result[WIDTH-1];
    mag_in = neg_in ? (~bus.result + WIDTH'(1)) : bus.result;
  end

  // One double-dabble step: fix digits >= 5, then shift in the next bit.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    scr_d = {adj[BW-2:0], mag_q[WIDTH-1]};
    mag_d = {mag_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      scr_q   <= '0;
      mag_q   <= '0;
      sneg_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.error) begin
              bcd_q   <= '0;
              neg_q   <= 1'b0;
              err_q   <= 1'b1;
              ov_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              sneg_q  <= neg_in;
              mag_q   <= mag_in;
              scr_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= CONV;
            end
          end
        end
        CONV: begin
          scr_q <= scr_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            bcd_q   <= scr_d;
            neg_q   <= sneg_q;
            err_q   <= 1'b0;
            ov_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = rst_n & (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.bcd       = bcd_q;
  assign bus.neg       = neg_q;
  assign bus.err_out   = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_calc_result_bcd.sv
// tb_calc_result_bcd: directed vectors for calc_result_bcd.
// Checks latency, busy span, BCD/sign/error values, backpressure and reset abort.
module tb_calc_result_bcd;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  calc_result_bcd_if bus ();

  calc_result_bcd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [7:0] r, input logic se, input logic er,
                     input bit garble, input int hold,
                     input logic [11:0] eb, input logic en,
                     input logic ee, input int el);
    int n;
    int nb;
    int held;
    chk("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_valid  = 1'b1;
    bus.result    = r;
    bus.signed_en = se;
    bus.error     = er;
    step();
    bus.in_valid = 1'b0;
    chk("in_ready_low", 32'(bus.in_ready), 0);
    n  = 0;
    nb = 0;
    while (!bus.out_valid && n < 40) begin
      if (bus.busy) nb++;
      if (garble) begin
        bus.in_valid  = 1'($urandom);
        bus.result    = 8'($urandom);
        bus.error     = 1'($urandom);
        bus.signed_en = 1'($urandom);
      end
      step();
      n++;
    end
    bus.in_valid = 1'b0;
    bus.error    = 1'b0;
    chk("latency", 32'(n), 32'(el));
    chk("busy_span", 32'(nb), er ? 0 : 32'(el));
    chk("busy_done", 32'(bus.busy), 0);
    chk("bcd", 32'(bus.bcd), 32'(eb));
    chk("neg", 32'(bus.neg), 32'(en));
    chk("err_out", 32'(bus.err_out), 32'(ee));
    if (hold > 0) begin
      held = 0;
      for (int i = 0; i < hold; i++) begin
        step();
        if (bus.out_valid && bus.bcd == eb && bus.in_ready == 1'b0) held++;
      end
      chk("held", 32'(held), 32'(hold));
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("ov_drop", 32'(bus.out_valid), 0);
    chk("in_ready_back", 32'(bus.in_ready), 1);
    chk("bcd_kept", 32'(bus.bcd), 32'(eb));
  endtask

  initial begin
    int quiet;
    nvec = 0;
    nerr = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.result    = '0;
    bus.error     = 1'b0;
    bus.signed_en = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_bcd", 32'(bus.bcd), 0);
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_flags", 32'({bus.neg, bus.err_out}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run(8'hEA, 1'b0, 1'b0, 1'b0, 0, 12'h234, 1'b0, 1'b0, 8);
    run(8'hF6, 1'b1, 1'b0, 1'b0, 0, 12'h010, 1'b1, 1'b0, 8);
    run(8'hF6, 1'b0, 1'b0, 1'b0, 0, 12'h246, 1'b0, 1'b0, 8);
    run(8'h80, 1'b1, 1'b0, 1'b0, 0, 12'h128, 1'b1, 1'b0, 8);
    run(8'h00, 1'b1, 1'b0, 1'b0, 0, 12'h000, 1'b0, 1'b0, 8);
    run(8'h55, 1'b0, 1'b1, 1'b0, 0, 12'h000, 1'b0, 1'b1, 0);
    run(8'h63, 1'b0, 1'b0, 1'b0, 5, 12'h099, 1'b0, 1'b0, 8);
    run(8'h7F, 1'b1, 1'b0, 1'b1, 0, 12'h127, 1'b0, 1'b0, 8);
    run(8'hFF, 1'b0, 1'b0, 1'b1, 2, 12'h255, 1'b0, 1'b0, 8);
    run(8'hFF, 1'b1, 1'b0, 1'b0, 0, 12'h001, 1'b1, 1'b0, 8);

    bus.in_valid  = 1'b1;
    bus.result    = 8'hC8;
    bus.signed_en = 1'b0;
    step();
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_bcd", 32'(bus.bcd), 0);
    chk("abort_ov", 32'(bus.out_valid), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_flags", 32'({bus.neg, bus.err_out}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(bus.in_ready), 1);
    quiet = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (!bus.out_valid && !bus.busy) quiet++;
    end
    chk("post_rst_quiet", 32'(quiet), 4);
    run(8'h07, 1'b0, 1'b0, 1'b0, 0, 12'h007, 1'b0, 1'b0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
